// File: rtl/shift_reg_sequencer_pkg.sv
// Shared encodings for the shift-register sequencer: opcodes, register mode
// codes, controller states and the opcode-to-mode mapping.
package shift_reg_sequencer_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_LOAD  = 3'b001,
        OP_SHL   = 3'b010,
        OP_SHR   = 3'b011,
        OP_ROTL  = 3'b100,
        OP_ROTR  = 3'b101,
        OP_CLEAR = 3'b110,
        OP_RSVD  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Rotates reuse the shift modes; the serial-in mux supplies the wrap bit.
    function automatic mode_e op_mode(input op_e op);
        mode_e m;
        case (op)
            OP_LOAD, OP_CLEAR: m = MODE_LOAD;
            OP_SHL, OP_ROTL:   m = MODE_SHL;
            OP_SHR, OP_ROTR:   m = MODE_SHR;
            default:           m = MODE_HOLD;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/shift_reg_sequencer_step_counter.sv
// Loadable down-counter tracking remaining register steps; flags the final step.
module step_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             last_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins over decrement; never wraps below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != {CNT_W{1'b0}})) begin
            cnt_d = cnt_q - CNT_W'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == CNT_W'(1'b1));

endmodule

// File: rtl/shift_reg_sequencer.sv
// Command sequencer for a universal shift register: accepts one command per
// handshake, drives mode/serial/parallel pins for each step, then pulses done.
module shift_reg_sequencer
    import shift_reg_sequencer_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [2:0]       cmd_op_i,
    input  logic [CNT_W-1:0] cmd_cnt_i,
    input  logic [WIDTH-1:0] cmd_data_i,
    input  logic             cmd_sin_i,
    input  logic             abort_i,
    input  logic [WIDTH-1:0] reg_q_i,
    output logic [1:0]       mode_o,
    output logic             ser_r_o,
    output logic             ser_l_o,
    output logic [WIDTH-1:0] par_d_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             aborted_o
);

    state_e           state_q;
    op_e              op_q;
    logic             sin_q;
    mode_e            mode_q;
    logic [WIDTH-1:0] par_d_q;
    logic             done_q;
    logic             aborted_q;
    logic             busy_q;

    op_e              cmd_op_s;
    logic             accept_s;
    logic             run_s;
    logic             last_s;
    logic [CNT_W-1:0] load_val_s;
    logic             ser_r_s;
    logic             ser_l_s;
    logic             reg_q_unused_s;

    assign cmd_op_s       = op_e'(cmd_op_i);
    assign accept_s       = cmd_valid_i && (state_q == ST_IDLE);
    assign run_s          = (state_q == ST_RUN);
    assign reg_q_unused_s = ^reg_q_i;

    // Steps to run for an incoming command; zero means finish immediately.
    always_comb begin
        load_val_s = {CNT_W{1'b0}};
        case (cmd_op_s)
            OP_LOAD, OP_CLEAR:                load_val_s = CNT_W'(1'b1);
            OP_SHL, OP_SHR, OP_ROTL, OP_ROTR: load_val_s = cmd_cnt_i;
            default:                          load_val_s = {CNT_W{1'b0}};
        endcase
    end

    step_counter #(
        .CNT_W (CNT_W)
    ) u_step_counter (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (accept_s),
        .load_val_i (load_val_s),
        .dec_i      (run_s),
        .last_o     (last_s)
    );

    // Controller FSM with registered mode, data and status outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_NOP;
            sin_q     <= 1'b0;
            mode_q    <= MODE_HOLD;
            par_d_q   <= {WIDTH{1'b0}};
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q    <= 1'b0;
                    aborted_q <= 1'b0;
                    if (accept_s) begin
                        op_q   <= cmd_op_s;
                        sin_q  <= cmd_sin_i;
                        busy_q <= 1'b1;
                        if (load_val_s != {CNT_W{1'b0}}) begin
                            state_q <= ST_RUN;
                            mode_q  <= op_mode(cmd_op_s);
                            par_d_q <= (cmd_op_s == OP_LOAD) ? cmd_data_i : {WIDTH{1'b0}};
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // The step on this edge always completes, even when aborted.
                    if (last_s || abort_i) begin
                        state_q   <= ST_DONE;
                        mode_q    <= MODE_HOLD;
                        par_d_q   <= {WIDTH{1'b0}};
                        done_q    <= 1'b1;
                        aborted_q <= abort_i;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_q   <= ST_IDLE;
                    done_q    <= 1'b0;
                    aborted_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    mode_q    <= MODE_HOLD;
                    par_d_q   <= {WIDTH{1'b0}};
                    done_q    <= 1'b0;
                    aborted_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    // Serial-in mux: fill bit for shifts, wrap-around bit for rotates.
    always_comb begin
        ser_r_s = 1'b0;
        ser_l_s = 1'b0;
        if (run_s) begin
            case (op_q)
                OP_SHL:  ser_l_s = sin_q;
                OP_SHR:  ser_r_s = sin_q;
                OP_ROTL: ser_l_s = reg_q_i[WIDTH-1];
                OP_ROTR: ser_r_s = reg_q_i[0];
                default: begin
                    ser_r_s = 1'b0;
                    ser_l_s = 1'b0;
                end
            endcase
        end else begin
            ser_r_s = 1'b0;
            ser_l_s = 1'b0;
        end
    end

    assign cmd_ready_o = (state_q == ST_IDLE);
    assign mode_o      = mode_q;
    assign par_d_o     = par_d_q;
    assign ser_r_o     = ser_r_s;
    assign ser_l_o     = ser_l_s;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign aborted_o   = aborted_q;

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Scoreboard bench: a 4-bit shift-register model is driven by the sequencer;
// commands push expected results, a monitor pops and compares on each done.
module tb_shift_reg_sequencer;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_op = 3'b000;
    logic [CNT_W-1:0] cmd_cnt = 3'd0;
    logic [WIDTH-1:0] cmd_data = 4'b0000;
    logic             cmd_sin = 1'b0;
    logic             abort = 1'b0;
    logic [WIDTH-1:0] reg_m = 4'b0000;
    logic [1:0]       mode;
    logic             ser_r;
    logic             ser_l;
    logic [WIDTH-1:0] par_d;
    logic             busy;
    logic             done;
    logic             aborted;

    typedef struct {
        logic [3:0] reg_v;
        logic       ab;
        int         lat;
        int         steps;
        logic [1:0] mode;
        int         acc;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         n_pass = 0;
    int         n_total = 0;
    logic [2:0] cur_op = 3'b000;
    logic       cur_sin = 1'b0;

    shift_reg_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_op_i    (cmd_op),
        .cmd_cnt_i   (cmd_cnt),
        .cmd_data_i  (cmd_data),
        .cmd_sin_i   (cmd_sin),
        .abort_i     (abort),
        .reg_q_i     (reg_m),
        .mode_o      (mode),
        .ser_r_o     (ser_r),
        .ser_l_o     (ser_l),
        .par_d_o     (par_d),
        .busy_o      (busy),
        .done_o      (done),
        .aborted_o   (aborted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Universal shift register datapath model.
    always @(posedge clk) begin
        case (mode)
            2'b01:   reg_m <= {ser_r, reg_m[3:1]};
            2'b10:   reg_m <= {reg_m[2:0], ser_l};
            2'b11:   reg_m <= par_d;
            default: reg_m <= reg_m;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    endtask

    // Monitor: checks serial inputs every step and pops the scoreboard on done.
    initial begin
        int   mode_cnt;
        bit   mode_bad;
        logic exp_l;
        logic exp_r;
        exp_t e;
        mode_cnt = 0;
        mode_bad = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mode_cnt = 0;
                mode_bad = 1'b0;
            end else begin
                if (mode != 2'b00) begin
                    mode_cnt++;
                    if (sb.size() == 0 || mode != sb[0].mode) mode_bad = 1'b1;
                    exp_l = (cur_op == 3'b010) ? cur_sin : (cur_op == 3'b100) ? reg_m[3] : 1'b0;
                    exp_r = (cur_op == 3'b011) ? cur_sin : (cur_op == 3'b101) ? reg_m[0] : 1'b0;
                    chk("ser_l", 32'(ser_l), 32'(exp_l));
                    chk("ser_r", 32'(ser_r), 32'(exp_r));
                    chk("busy_run", 32'(busy), 32'd1);
                end
                if (done) begin
                    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("reg_q", 32'(reg_m), 32'(e.reg_v));
                        chk("aborted", 32'(aborted), 32'(e.ab));
                        chk("done_latency", 32'(cyc - e.acc), 32'(e.lat));
                        chk("step_cycles", 32'(mode_cnt), 32'(e.steps));
                        chk("mode_value", 32'(mode_bad), 32'd0);
                    end
                    mode_cnt = 0;
                    mode_bad = 1'b0;
                end
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [2:0] cnt, input logic [3:0] data,
                         input logic sin, input logic [3:0] x_reg, input logic x_ab,
                         input int x_lat, input int x_steps, input logic [1:0] x_mode,
                         input bit hold, output int acc);
        exp_t e;
        int   w;
        w = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_cnt   = cnt;
        cmd_data  = data;
        cmd_sin   = sin;
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            chk("ready_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            acc = -1;
            return;
        end
        e.reg_v = x_reg;
        e.ab    = x_ab;
        e.lat   = x_lat;
        e.steps = x_steps;
        e.mode  = x_mode;
        e.acc   = cyc + 1;
        acc     = e.acc;
        sb.push_back(e);
        @(posedge clk);
        cur_op  = op;
        cur_sin = sin;
        #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1;
        int a2;
        #3;
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_mode", 32'(mode), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_aborted", 32'(aborted), 32'd0);
        chk("rst_par_d", 32'(par_d), 32'd0);
        chk("rst_ser", 32'({ser_r, ser_l}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(3'b001, 3'd0, 4'b1010, 1'b0, 4'b1010, 1'b0, 1, 1, 2'b11, 1'b0, a1);
        issue(3'b110, 3'd0, 4'b1111, 1'b0, 4'b0000, 1'b0, 1, 1, 2'b11, 1'b0, a1);
        issue(3'b011, 3'd2, 4'b0000, 1'b1, 4'b1100, 1'b0, 2, 2, 2'b01, 1'b0, a1);
        issue(3'b001, 3'd0, 4'b1001, 1'b0, 4'b1001, 1'b0, 1, 1, 2'b11, 1'b0, a1);
        issue(3'b100, 3'd5, 4'b0000, 1'b0, 4'b0011, 1'b0, 5, 5, 2'b10, 1'b0, a1);
        issue(3'b001, 3'd0, 4'b0001, 1'b0, 4'b0001, 1'b0, 1, 1, 2'b11, 1'b0, a1);
        issue(3'b010, 3'd7, 4'b0000, 1'b0, 4'b1000, 1'b1, 3, 3, 2'b10, 1'b0, a1);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;

        issue(3'b011, 3'd0, 4'b0000, 1'b1, 4'b1000, 1'b0, 0, 0, 2'b00, 1'b1, a1);
        issue(3'b000, 3'd3, 4'b0000, 1'b0, 4'b1000, 1'b0, 0, 0, 2'b00, 1'b0, a2);
        chk("accept_gap", 32'(a2 - a1), 32'd2);
        issue(3'b111, 3'd4, 4'b0110, 1'b1, 4'b1000, 1'b0, 0, 0, 2'b00, 1'b0, a1);
        issue(3'b010, 3'd6, 4'b0000, 1'b1, 4'b1111, 1'b0, 6, 6, 2'b10, 1'b0, a1);
        issue(3'b001, 3'd0, 4'b0110, 1'b0, 4'b0110, 1'b0, 1, 1, 2'b11, 1'b0, a1);
        issue(3'b101, 3'd5, 4'b0000, 1'b0, 4'b0011, 1'b0, 5, 5, 2'b01, 1'b0, a1);
        issue(3'b011, 3'd2, 4'b0000, 1'b0, 4'b0000, 1'b1, 2, 2, 2'b01, 1'b0, a1);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        drain();

        abort = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_abort_aborted", 32'(aborted), 32'd0);
        chk("idle_abort_busy", 32'(busy), 32'd0);
        abort = 1'b0;
        issue(3'b001, 3'd0, 4'b0101, 1'b0, 4'b0101, 1'b0, 1, 1, 2'b11, 1'b0, a1);

        issue(3'b001, 3'd0, 4'b1001, 1'b0, 4'b1001, 1'b0, 1, 1, 2'b11, 1'b0, a1);
        issue(3'b101, 3'd6, 4'b0000, 1'b0, 4'b1001, 1'b0, 6, 6, 2'b01, 1'b0, a1);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mode", 32'(mode), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
        chk("mid_rst_ser", 32'({ser_r, ser_l}), 32'd0);
        sb.delete();
        cur_op = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("reg_after_rst", 32'(reg_m), 32'(4'b1100));
        chk("idle_after_rst", 32'(done), 32'd0);
        issue(3'b001, 3'd0, 4'b0111, 1'b0, 4'b0111, 1'b0, 1, 1, 2'b11, 1'b0, a1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
